// File: rtl/eps_greedy_gen.sv
// Epsilon-greedy sample generator: a 16-bit Fibonacci LFSR produces Arand and Asel, and epsilon decays once per episode.
// Optional build macro EPS_GREEDY_SEED_LOAD_EN adds the seed_load/seed_in ports for runtime LFSR reseeding.
`timescale 1ns/1ps
module eps_greedy_gen #(
    parameter int unsigned         LFSR_W      = 16,
    parameter logic [LFSR_W-1:0]   SEED        = 16'hACE1,
    parameter int unsigned         EPS_W       = 16,
    parameter logic [EPS_W-1:0]    EPS_INIT    = 16'hFFFF,
    parameter logic [EPS_W-1:0]    EPS_MIN     = 16'h0CCD,
    parameter int unsigned         DECAY_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              episode_done,
    input  logic              learning,
`ifdef EPS_GREEDY_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic [1:0]        Arand,
    output logic              Asel,
    output logic              valid,
    output logic [EPS_W-1:0]  epsilon,
    output logic [15:0]       episode_cnt,
    output logic              at_floor
);

    typedef enum logic [0:0] {
        ST_DECAY = 1'b0,
        ST_FLOOR = 1'b1
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF      = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam bit                INIT_AT_FLOOR = (EPS_INIT <= EPS_MIN);
    localparam logic [EPS_W-1:0]  EPS_RESET     = INIT_AT_FLOOR ? EPS_MIN : EPS_INIT;
    localparam state_t            STATE_RESET   = INIT_AT_FLOOR ? ST_FLOOR : ST_DECAY;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [EPS_W-1:0]  eps_q, eps_d;
    state_t            state_q, state_d;
    logic [1:0]        arand_q, arand_d;
    logic              asel_q, asel_d;
    logic              valid_q, valid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              fb;
    logic [LFSR_W-1:0] lfsr_adv;
    logic [EPS_W-1:0]  rnd;
    logic [EPS_W-1:0]  eps_dec;
    logic [EPS_W-1:0]  eps_nxt;
    logic              ep_en;
    logic              seed_load_w;
    logic [LFSR_W-1:0] seed_val_w;

`ifdef EPS_GREEDY_SEED_LOAD_EN
    assign seed_load_w = seed_load;
    assign seed_val_w  = (seed_in == '0) ? LFSR_W'(1) : seed_in;
`else
    assign seed_load_w = 1'b0;
    assign seed_val_w  = SEED_EFF;
`endif

    always_comb begin
        fb       = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
        lfsr_adv = (lfsr_q == '0) ? LFSR_W'(1) : {lfsr_q[LFSR_W-2:0], fb};
        rnd      = lfsr_adv[LFSR_W-1 -: EPS_W];
    end

    // Output handshake: valid is a one-cycle strobe with no ready; a consumer
    // must take Arand/Asel in the cycle valid is high. Back-to-back steps keep
    // valid high with a fresh sample every cycle. Arand/Asel hold otherwise.
    always_comb begin
        lfsr_d  = lfsr_q;
        arand_d = arand_q;
        asel_d  = asel_q;
        valid_d = 1'b0;
        if (seed_load_w) begin
            lfsr_d = seed_val_w;
        end else if (step) begin
            lfsr_d  = lfsr_adv;
            arand_d = lfsr_adv[1:0];
            asel_d  = (rnd >= eps_q);
            valid_d = 1'b1;
        end
    end

    // Epsilon FSM; the sample above always sees eps_q from before this edge's decay.
    always_comb begin
        state_d = state_q;
        eps_d   = eps_q;
        cnt_d   = cnt_q;
        eps_dec = eps_q >> DECAY_SHIFT;
        eps_nxt = eps_q - eps_dec;
        ep_en   = episode_done & learning;

        if (ep_en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            ST_DECAY: begin
                if (ep_en) begin
                    if ((eps_dec == '0) || (eps_nxt <= EPS_MIN)) begin
                        eps_d   = EPS_MIN;
                        state_d = ST_FLOOR;
                    end else begin
                        eps_d = eps_nxt;
                    end
                end
            end
            ST_FLOOR: begin
                eps_d = EPS_MIN;
            end
            default: begin
                state_d = STATE_RESET;
                eps_d   = EPS_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q  <= SEED_EFF;
            eps_q   <= EPS_RESET;
            state_q <= STATE_RESET;
            arand_q <= 2'd0;
            asel_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            eps_q   <= eps_d;
            state_q <= state_d;
            arand_q <= arand_d;
            asel_q  <= asel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Arand       = arand_q;
    assign Asel        = asel_q;
    assign valid       = valid_q;
    assign epsilon     = eps_q;
    assign episode_cnt = cnt_q;
    assign at_floor    = (state_q == ST_FLOOR);

endmodule

// File: tb/tb_eps_greedy_gen.sv
// Directed bench for eps_greedy_gen: three parameterisations, a vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_eps_greedy_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: default parameters
    logic a_step = 0, a_ed = 0, a_learn = 0;
    logic [1:0]  a_arand;
    logic        a_asel, a_valid, a_floor;
    logic [15:0] a_eps, a_cnt;

    // Instance B: fast floor
    logic b_step = 0, b_ed = 0, b_learn = 0;
    logic [1:0]  b_arand;
    logic        b_asel, b_valid, b_floor;
    logic [15:0] b_eps, b_cnt;

    // Instance C: zero epsilon, zero floor
    logic c_step = 0, c_ed = 0, c_learn = 0;
    logic [1:0]  c_arand;
    logic        c_asel, c_valid, c_floor;
    logic [15:0] c_eps, c_cnt;

    eps_greedy_gen u_a (
        .clk(clk), .rst(rst), .step(a_step), .episode_done(a_ed), .learning(a_learn),
`ifdef EPS_GREEDY_SEED_LOAD_EN
        .seed_load(1'b0), .seed_in(16'h0000),
`endif
        .Arand(a_arand), .Asel(a_asel), .valid(a_valid), .epsilon(a_eps),
        .episode_cnt(a_cnt), .at_floor(a_floor)
    );

    eps_greedy_gen #(.EPS_INIT(16'h0010), .EPS_MIN(16'h000A), .DECAY_SHIFT(1)) u_b (
        .clk(clk), .rst(rst), .step(b_step), .episode_done(b_ed), .learning(b_learn),
`ifdef EPS_GREEDY_SEED_LOAD_EN
        .seed_load(1'b0), .seed_in(16'h0000),
`endif
        .Arand(b_arand), .Asel(b_asel), .valid(b_valid), .epsilon(b_eps),
        .episode_cnt(b_cnt), .at_floor(b_floor)
    );

    eps_greedy_gen #(.EPS_INIT(16'h0000), .EPS_MIN(16'h0000)) u_c (
        .clk(clk), .rst(rst), .step(c_step), .episode_done(c_ed), .learning(c_learn),
`ifdef EPS_GREEDY_SEED_LOAD_EN
        .seed_load(1'b0), .seed_in(16'h0000),
`endif
        .Arand(c_arand), .Asel(c_asel), .valid(c_valid), .epsilon(c_eps),
        .episode_cnt(c_cnt), .at_floor(c_floor)
    );

    typedef struct {
        logic        step;
        logic        ed;
        logic        learn;
        logic        exp_valid;
        logic [1:0]  exp_arand;
        logic        exp_asel;
        logic [15:0] exp_eps;
        logic [15:0] exp_cnt;
        logic        exp_floor;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] l);
        if (l == 16'h0000) return 16'h0001;
        return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] m;
        logic [3:0]  seen;

        // step, ed, learn | valid, Arand, Asel, eps, cnt, floor
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 16'hFFFF, 16'd0, 1'b0}; // lfsr 59C3
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 16'hFFFF, 16'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 16'hF000, 16'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 16'hE100, 16'd2, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 16'hE100, 16'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 16'hD2F0, 16'd3, 1'b0}; // lfsr B386
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'hD2F0, 16'd3, 1'b0}; // lfsr 670C
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'hD2F0, 16'd3, 1'b0}; // lfsr CE18
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'hD2F0, 16'd3, 1'b0}; // lfsr 9C31
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 16'hD2F0, 16'd3, 1'b0};

        // Reset state of all three instances
        rst = 1'b0;
        repeat (2) tick();
        check("a_rst_valid", 16'(a_valid), 16'd0);
        check("a_rst_arand", 16'(a_arand), 16'd0);
        check("a_rst_asel",  16'(a_asel),  16'd0);
        check("a_rst_eps",   a_eps,        16'hFFFF);
        check("a_rst_cnt",   a_cnt,        16'd0);
        check("a_rst_floor", 16'(a_floor), 16'd0);
        check("b_rst_eps",   b_eps,        16'h0010);
        check("b_rst_floor", 16'(b_floor), 16'd0);
        check("c_rst_eps",   c_eps,        16'h0000);
        check("c_rst_floor", 16'(c_floor), 16'd1);
        rst = 1'b1;

        // Table-driven vectors on instance A
        for (int i = 0; i < 10; i++) begin
            a_step = vecs[i].step; a_ed = vecs[i].ed; a_learn = vecs[i].learn;
            tick();
            a_step = 1'b0; a_ed = 1'b0; a_learn = 1'b0;
            check($sformatf("a_v%0d_valid", i), 16'(a_valid), 16'(vecs[i].exp_valid));
            check($sformatf("a_v%0d_arand", i), 16'(a_arand), 16'(vecs[i].exp_arand));
            check($sformatf("a_v%0d_asel",  i), 16'(a_asel),  16'(vecs[i].exp_asel));
            check($sformatf("a_v%0d_eps",   i), a_eps,        vecs[i].exp_eps);
            check($sformatf("a_v%0d_cnt",   i), a_cnt,        vecs[i].exp_cnt);
            check($sformatf("a_v%0d_floor", i), 16'(a_floor), 16'(vecs[i].exp_floor));
        end

        // Instance B: one decay lands on the floor, further pulses only count
        b_ed = 1'b1; b_learn = 1'b1;
        tick();
        check("b_ep1_eps",   b_eps,        16'h000A);
        check("b_ep1_floor", 16'(b_floor), 16'd1);
        check("b_ep1_cnt",   b_cnt,        16'd1);
        repeat (2) tick();
        check("b_ep3_eps",   b_eps,        16'h000A);
        check("b_ep3_cnt",   b_cnt,        16'd3);
        check("b_ep3_floor", 16'(b_floor), 16'd1);
        b_learn = 1'b0;
        tick();
        b_ed = 1'b0;
        check("b_nolearn_cnt", b_cnt, 16'd3);
        check("b_nolearn_eps", b_eps, 16'h000A);

        // Instance C: 1000 back-to-back steps against an LFSR reference
        m = 16'hACE1;
        seen = 4'h0;
        c_step = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            m = lfsr_model(m);
            seen[c_arand] = 1'b1;
            check("c_run_valid", 16'(c_valid), 16'd1);
            check("c_run_asel",  16'(c_asel),  16'd1);
            check("c_run_arand", 16'(c_arand), 16'(m[1:0]));
        end
        c_step = 1'b0;
        tick();
        check("c_after_valid", 16'(c_valid), 16'd0);
        check("c_all_arand",   16'(seen),    16'h000F);
        check("c_eps_hold",    c_eps,        16'h0000);

        // Reset mid-operation with step and episode_done pulses present
        a_step = 1'b1; a_ed = 1'b1; a_learn = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_step = 1'b0; a_ed = 1'b0; a_learn = 1'b0;
        check("a_mrst_valid", 16'(a_valid), 16'd0);
        check("a_mrst_arand", 16'(a_arand), 16'd0);
        check("a_mrst_eps",   a_eps,        16'hFFFF);
        check("a_mrst_cnt",   a_cnt,        16'd0);
        check("b_mrst_floor", 16'(b_floor), 16'd0);
        check("b_mrst_eps",   b_eps,        16'h0010);

        // Simultaneous step and episode_done right after reset
        a_step = 1'b1; a_ed = 1'b1; a_learn = 1'b1;
        tick();
        a_step = 1'b0; a_ed = 1'b0; a_learn = 1'b0;
        check("a_sim_valid", 16'(a_valid), 16'd1);
        check("a_sim_arand", 16'(a_arand), 16'd3);
        check("a_sim_asel",  16'(a_asel),  16'd0);
        check("a_sim_eps",   a_eps,        16'hF000);
        check("a_sim_cnt",   a_cnt,        16'd1);
        tick();
        check("a_sim_valid_drop", 16'(a_valid), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eps_greedy_gen.md
Name: eps_greedy_gen

Overview:
- Upstream stage of the policy generator: produces the per-step random action `Arand` and the exploit/explore select `Asel` for epsilon-greedy action choice.
- Holds a 16-bit Fibonacci LFSR and an epsilon threshold register.
- Epsilon decays geometrically once per episode while learning and saturates at a floor.
- Outputs are registered and feed the policy generator's `Arand`/`Asel` inputs directly.

Parameters:
- LFSR_W, 16, LFSR width; taps fixed for 16 (x^16+x^15+x^13+x^4+1).
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- EPS_W, 16, epsilon/compare width (<= LFSR_W).
- EPS_INIT, 16'hFFFF, epsilon after reset; exploration probability is eps/2^EPS_W.
- EPS_MIN, 16'h0CCD, epsilon floor (~5%).
- DECAY_SHIFT, 4, per-episode decay: eps <= eps - (eps >> DECAY_SHIFT).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- step  in  1  one-cycle pulse: draw a new action sample.
- episode_done  in  1  one-cycle pulse: end of episode, decay epsilon.
- learning  in  1  1 = learning phase; epsilon decays only when high.
- Arand  out  2  random action index, registered.
- Asel  out  1  1 = exploit (greedy), 0 = explore; registered.
- valid  out  1  one-cycle pulse, Arand/Asel updated this cycle.
- epsilon  out  EPS_W  current threshold.
- episode_cnt  out  16  episodes seen while learning, saturating.
- at_floor  out  1  FSM in FLOOR.

Behaviour:
- Reset (rst==0 at posedge):
  - lfsr=SEED (or 1 if SEED==0), eps=EPS_INIT.
  - Arand=0, Asel=0, valid=0, episode_cnt=0.
  - FSM=DECAY, or FLOOR if EPS_INIT<=EPS_MIN (then eps=EPS_MIN).
  - Reset mid-operation discards all state, including any step/episode_done pulse in the same cycle.
- LFSR:
  - Advances only on step.
  - fb = l[15]^l[14]^l[12]^l[3]; lfsr_next = {l[14:0], fb}.
  - If lfsr is ever 0, lfsr_next = 16'h0001 (zero-lock guard).
- Sampling, 1-cycle latency: on step, at the same edge:
  - Arand <= lfsr_next[1:0].
  - rnd = lfsr_next[LFSR_W-1 -: EPS_W].
  - Asel <= (rnd >= eps), unsigned compare, using eps before any same-edge decay.
  - valid <= 1; valid is 0 in every cycle after a non-step edge.
  - Without step, Arand/Asel hold.
- Back-to-back steps every cycle are legal: one fresh sample per cycle, valid stays high.
- FSM, 2 states:
  - DECAY: on episode_done & learning:
    - d = eps >> DECAY_SHIFT; n = eps - d.
    - If d==0 or n<=EPS_MIN: eps <= EPS_MIN, go FLOOR. Else eps <= n.
  - FLOOR: eps holds at EPS_MIN. No exit except reset.
- episode_done with learning=0: eps and FSM unchanged, episode_cnt unchanged.
- episode_cnt:
  - +1 on each episode_done & learning, in both states.
  - Saturates at 16'hFFFF.
- Simultaneous step and episode_done: both take effect. The sample compares against the old eps; eps updates at the same edge.
- Asel and learning are independent: the downstream gating (A = Asel & learning ? greedy : Arand) is not duplicated here.
- EPS_MIN=0: the floor is 0 and Asel is always 1 in FLOOR.

Optional Feature:
- Macro: EPS_GREEDY_SEED_LOAD_EN.
- When defined, adds ports seed_load (in, 1) and seed_in (in, LFSR_W).
  - seed_load=1 at posedge: lfsr <= (seed_in==0 ? 1 : seed_in).
  - seed_load has priority over step in the same cycle; the step is ignored and valid stays 0.
  - eps, FSM and counters are unaffected.
- When undefined: the ports do not exist and the LFSR is seeded only by reset.

Test Plan:
- Reset, defaults, single step pulse -> next cycle: valid=1, Arand=3, Asel=0 (rnd 16'h59C3 < eps 16'hFFFF); lfsr=16'h59C3. valid=0 one cycle later.
- learning=1, two episode_done pulses -> epsilon 16'hFFFF -> 16'hF000 -> 16'hE100; episode_cnt=2; at_floor=0.
- EPS_INIT=16'h0010, EPS_MIN=16'h000A, DECAY_SHIFT=1, one episode_done -> epsilon=16'h000A, at_floor=1. Further pulses keep 16'h000A; episode_cnt still increments.
- learning=0, episode_done -> epsilon and episode_cnt unchanged.
- step and episode_done on the same cycle after reset -> Asel computed against 16'hFFFF (=0); epsilon=16'hF000 next cycle.
- EPS_INIT=0, EPS_MIN=0, 1000 consecutive steps -> Asel=1 every sample, valid high every cycle after the first step. LFSR never 0, and all four Arand values appear.
